audio_pcm_feeder: RTL
=====================

AUDIO_PCM_FEEDER -- requirements
Module: audio_pcm_feeder

Interface
REQ-001 Parameter BITDEPTH, default 14: PCM sample width, matching the sigma-delta DAC input.
REQ-002 Parameter FIFO_LOG2, default 4: FIFO depth is 2^FIFO_LOG2 entries (16).
REQ-003 Parameter CLK_DIV, default 1000: clk cycles per output sample period; legal range 2..65535.
REQ-004 clk  input  1  single clock; all state sampled on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (0 = in reset); release is synchronous to clk.
REQ-006 enable  input  1  1 = sample clock runs; 0 = playback halted, output silence.
REQ-007 in_data  input  BITDEPTH  two's-complement sample from the producer.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_ready  output  1  FIFO can accept a sample this cycle.
REQ-010 clr_underrun  input  1  synchronous clear of the underrun flag.
REQ-011 pcm  output  BITDEPTH  offset-binary sample to the DAC; registered.
REQ-012 sample_tick  output  1  one-cycle pulse marking each sample period.
REQ-013 underrun  output  1  sticky: a tick found the FIFO empty.
REQ-014 level  output  FIFO_LOG2+1  current FIFO occupancy, 0..2^FIFO_LOG2.

Function
REQ-015 Divider counter counts 0..CLK_DIV-1 while enable=1, then wraps to 0; held at 0 while enable=0.
REQ-016 sample_tick = 1 exactly when enable=1 and the counter equals CLK_DIV-1; the period is exactly CLK_DIV cycles.
REQ-017 in_ready = 1 when level < 2^FIFO_LOG2 and rst=1; otherwise 0.
REQ-018 Push occurs on a clk edge where in_valid=1 and in_ready=1; in_data is written at the tail.
REQ-019 Pop occurs on a clk edge where sample_tick=1 and level>0; the head entry loads pcm on that edge with its MSB inverted (signed to offset binary).
REQ-020 Push on a full FIFO cannot occur (in_ready=0); the producer holds in_valid/in_data until accepted.
REQ-021 No bypass: a sample pushed on the same edge as a tick that sees level=0 is not popped; that tick is an underrun, and the sample is stored.
REQ-022 Push and pop on the same edge with 0<level<full: level unchanged, both pointers advance.
REQ-023 Read/write pointers wrap modulo 2^FIFO_LOG2; level is derived consistently from push/pop and never exceeds 2^FIFO_LOG2 or goes below 0.
REQ-024 Tick with level=0: pcm holds its previous value, and underrun sets on that edge.
REQ-025 underrun clears on an edge with clr_underrun=1, unless an underrun event occurs on the same edge, in which case set wins.
REQ-026 While enable=0: pcm is forced to midscale 2^(BITDEPTH-1) on each edge, no pops occur, and pushes continue normally.
REQ-027 On enable 0->1 the first tick occurs CLK_DIV cycles after the first edge with enable=1.
REQ-028 Latency: a sample reaches pcm on the edge of the first tick after it is written, at earliest the next edge.

Reset
REQ-029 rst=0 asynchronously sets: pcm = 2^(BITDEPTH-1) (0x2000 at 14 bits), counter = 0, pointers = 0, level = 0, underrun = 0.
REQ-030 While rst=0: sample_tick = 0, in_ready = 0, and in_valid is ignored.
REQ-031 Reset asserted mid-operation discards all FIFO contents; no sample in flight is preserved.

Verification (CLK_DIV=8, BITDEPTH=14, FIFO_LOG2=4)
REQ-032 Reset then idle with enable=1 -> pcm=0x2000; first tick at cycle 8; underrun=1 after that edge.
REQ-033 Push 0x0000, 0x1FFF, 0x2000, 0x3FFF, then run 4 ticks -> pcm sequence 0x2000, 0x3FFF, 0x0000, 0x1FFF, each loaded on its tick edge; level returns to 0.
REQ-034 Push 17 samples back-to-back with enable=0 -> 16 accepted, in_ready=0 with level=16; after the next tick, in_ready=1 and the 17th sample is accepted.
REQ-035 level=0 and push coincides with a tick -> underrun=1, pcm unchanged, level=1; the next tick pops the sample.
REQ-036 Assert clr_underrun on the same edge as an empty tick -> underrun stays 1; on a later edge with no event -> underrun=0.
REQ-037 Assert rst for 1 cycle mid-stream with level=5 -> level=0, pcm=0x2000 immediately (asynchronous); the tick period restarts at 8 cycles after release.

Source files
------------

// File: rtl/audio_pcm_feeder.sv
// Purpose: buffers producer PCM samples in a small FIFO and hands one to the sigma-delta DAC every CLK_DIV clocks.
// Latency: a stored sample reaches pcm on the first sample_tick edge after it is written (earliest: the next edge).
// Backpressure: in_ready drops while the FIFO is full or reset is held; the producer holds in_valid/in_data until accepted.
//
// Ports:
//   clk, rst          single clock; asynchronous active-low reset, released synchronously
//   enable            1 = sample clock runs; 0 = pcm forced to midscale, no pops (pushes still accepted)
//   in_data/in_valid  two's-complement sample from the producer; in_ready = FIFO has room
//   clr_underrun      synchronous clear of the sticky underrun flag (an underrun on the same edge wins)
//   pcm               registered offset-binary sample to the DAC
//   sample_tick       one-cycle pulse marking each sample period
//   underrun          sticky: a tick found the FIFO empty
//   level             FIFO occupancy, 0..2^FIFO_LOG2
module audio_pcm_feeder #(
  parameter int BITDEPTH  = 14,
  parameter int FIFO_LOG2 = 4,
  parameter int CLK_DIV   = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [BITDEPTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 clr_underrun,
  output logic [BITDEPTH-1:0]  pcm,
  output logic                 sample_tick,
  output logic                 underrun,
  output logic [FIFO_LOG2:0]   level
);

  localparam int                 DEPTH    = 1 << FIFO_LOG2;
  localparam logic [BITDEPTH-1:0] MIDSCALE = {1'b1, {(BITDEPTH-1){1'b0}}};
  localparam logic [15:0]        DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [FIFO_LOG2:0] FULL     = (FIFO_LOG2+1)'(DEPTH);

  logic [15:0]          div_cnt;
  logic [FIFO_LOG2-1:0] wr_ptr;
  logic [FIFO_LOG2-1:0] rd_ptr;
  logic [BITDEPTH-1:0]  mem [DEPTH];
  logic [BITDEPTH-1:0]  head;
  logic                 push;
  logic                 pop;
  logic                 starve;

  // Sample-period divider: free-runs 0..CLK_DIV-1 while enabled, parked at 0
  // otherwise so the first tick after enabling lands a full period later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (!enable || div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // rst gating keeps tick and ready low for the whole time reset is held,
  // not just from the next edge.
  assign sample_tick = rst & enable & (div_cnt == DIV_LAST);
  assign in_ready    = rst & (level != FULL);

  // Pop decision looks only at the pre-edge level: a sample arriving on the
  // same edge as a tick on an empty FIFO is stored, never bypassed.
  assign push   = in_valid & in_ready;
  assign pop    = sample_tick & (level != '0);
  assign starve = sample_tick & (level == '0);
  assign head   = mem[rd_ptr];

  // Storage carries no reset; validity is tracked entirely by the pointers/level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally at FIFO_LOG2 bits; level carries the extra bit
  // that distinguishes full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

  // Inverting the MSB maps two's complement onto offset binary for the DAC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcm <= MIDSCALE;
    end else if (!enable) begin
      pcm <= MIDSCALE;
    end else if (pop) begin
      pcm <= {~head[BITDEPTH-1], head[BITDEPTH-2:0]};
    end
  end

  // Set has priority over clear so an underrun coinciding with a clear is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun <= 1'b0;
    end else if (starve) begin
      underrun <= 1'b1;
    end else if (clr_underrun) begin
      underrun <= 1'b0;
    end
  end

endmodule
